id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline register of the five-stage MIPS core, with built-in load-use hazard detection and bubble insertion. It captures decoded operands, register addresses and control from ID. Its registered rs/rt outputs and operands feed the short_circuit forwarding unit and the EX stage. It drives o_stall back to the PC and IF/ID registers when a load-use dependency cannot be resolved by forwarding.

Parameters:
DATA_BUS_SIZE, 32, width of operand and immediate buses
REG_ADDR_SIZE, 5, register-file address width
CTRL_BUS_SIZE, 16, width of the opaque EX/MEM/WB control bundle passed through unchanged
STALL_CNT_SIZE, 16, width of the saturating stall counter

Ports:
i_clk  in  1  system clock, rising-edge
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  pipeline advance enable from the debug unit; low freezes the stage
i_flush  in  1  branch/jump taken; the next load is a bubble
i_id_rs  in  REG_ADDR_SIZE  ID rs address
i_id_rt  in  REG_ADDR_SIZE  ID rt address
i_id_rd  in  REG_ADDR_SIZE  ID rd address
i_id_uses_rt  in  1  ID instruction reads rt as a source
i_id_data_a  in  DATA_BUS_SIZE  register-file read A
i_id_data_b  in  DATA_BUS_SIZE  register-file read B
i_id_imm  in  DATA_BUS_SIZE  sign/zero-extended immediate
i_id_wb  in  1  instruction writes the register file
i_id_mem_read  in  1  instruction is a load
i_id_mem_write  in  1  instruction is a store
i_id_ctrl  in  CTRL_BUS_SIZE  remaining control bundle
o_id_ex_rs  out  REG_ADDR_SIZE  registered rs (to short_circuit)
o_id_ex_rt  out  REG_ADDR_SIZE  registered rt (to short_circuit)
o_id_ex_rd  out  REG_ADDR_SIZE  registered rd
o_id_ex_data_a  out  DATA_BUS_SIZE  registered operand A
o_id_ex_data_b  out  DATA_BUS_SIZE  registered operand B
o_id_ex_imm  out  DATA_BUS_SIZE  registered immediate
o_id_ex_wb  out  1  registered write-back enable
o_id_ex_mem_read  out  1  registered load flag
o_id_ex_mem_write  out  1  registered store flag
o_id_ex_ctrl  out  CTRL_BUS_SIZE  registered control bundle
o_stall  out  1  hold PC and IF/ID this cycle (combinational)
o_stall_count  out  STALL_CNT_SIZE  number of hazard stalls taken since reset

Behaviour:
- Reset (i_reset low, asynchronous): every registered output and o_stall_count go to 0. The stage then holds a bubble, so o_stall = 0.
- Hazard term (combinational): hazard = o_id_ex_mem_read & o_id_ex_wb & (o_id_ex_rt != 0) & ((o_id_ex_rt == i_id_rs) | (i_id_uses_rt & (o_id_ex_rt == i_id_rt))).
- o_stall = i_enable & hazard & ~i_flush.
- Each rising edge, priority order:
  1. i_enable low: all registers hold; counter holds.
  2. i_flush high: load a bubble.
  3. hazard high: load a bubble; increment o_stall_count.
  4. Otherwise: load all ID inputs.
- Bubble definition: wb, mem_read, mem_write, ctrl, rs, rt and rd all 0. data_a, data_b and imm are also loaded as 0, giving a deterministic value for the debug dump.
- Latency: one cycle from ID inputs to registered outputs.
- A load-use stall lasts exactly one cycle. The bubble clears mem_read, so hazard falls. IF/ID was held, so the same ID instruction is presented again and loads normally on the next edge.
- Back-to-back loads: a load that loads after a stall can itself trigger a stall for the following dependent instruction. Each occurrence costs exactly one cycle.
- Register 0: a load targeting $zero never stalls.
- Counter: o_stall_count saturates at all-ones and does not wrap.
- Flush and hazard in the same cycle: flush wins, o_stall = 0, and the counter does not increment.
- Reset asserted mid-stall: the stage clears immediately and o_stall drops in the same cycle.
- No combinational path from i_id_* to any registered output. o_stall is the only combinational output.

Test Plan:
- Reset: drive i_reset = 0 with random inputs, then release -> all outputs 0, o_stall = 0, o_stall_count = 0.
- Pass-through: i_enable = 1; load rs=3, rt=4, rd=5, data_a=0x11, data_b=0x22, imm=0xFFFF_FFF0, wb=1, ctrl=0x00A5 -> all values appear on outputs after one edge, o_stall = 0.
- Load-use on rs: cycle N loads lw with rt=8, wb=1, mem_read=1; cycle N+1 ID presents rs=8 -> o_stall = 1 during N+1. Edge N+1 loads a bubble (wb=0, mem_read=0) and o_stall_count = 1. Cycle N+2: o_stall = 0 and the rs=8 instruction loads.
- rt and $zero cases: lw rt=9 followed by ID rt=9 with i_id_uses_rt=0 -> no stall. Repeat with i_id_uses_rt=1 -> stall. lw rt=0 followed by ID rs=0 -> no stall.
- Flush priority: a hazard condition plus i_flush=1 -> o_stall = 0, bubble loaded, o_stall_count unchanged.
- Freeze: i_enable=0 for 3 cycles during a hazard -> outputs and counter hold, o_stall = 0. Re-enable -> stall taken once and counter increments by 1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// A one-cycle stall is requested when the EX-stage load feeds an ID source register.
module id_ex_stage #(
   parameter int DATA_BUS_SIZE  = 32,
   parameter int REG_ADDR_SIZE  = 5,
   parameter int CTRL_BUS_SIZE  = 16,
   parameter int STALL_CNT_SIZE = 16
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_flush,
   input  logic [REG_ADDR_SIZE-1:0]  i_id_rs,
   input  logic [REG_ADDR_SIZE-1:0]  i_id_rt,
   input  logic [REG_ADDR_SIZE-1:0]  i_id_rd,
   input  logic                      i_id_uses_rt,
   input  logic [DATA_BUS_SIZE-1:0]  i_id_data_a,
   input  logic [DATA_BUS_SIZE-1:0]  i_id_data_b,
   input  logic [DATA_BUS_SIZE-1:0]  i_id_imm,
   input  logic                      i_id_wb,
   input  logic                      i_id_mem_read,
   input  logic                      i_id_mem_write,
   input  logic [CTRL_BUS_SIZE-1:0]  i_id_ctrl,
   output logic [REG_ADDR_SIZE-1:0]  o_id_ex_rs,
   output logic [REG_ADDR_SIZE-1:0]  o_id_ex_rt,
   output logic [REG_ADDR_SIZE-1:0]  o_id_ex_rd,
   output logic [DATA_BUS_SIZE-1:0]  o_id_ex_data_a,
   output logic [DATA_BUS_SIZE-1:0]  o_id_ex_data_b,
   output logic [DATA_BUS_SIZE-1:0]  o_id_ex_imm,
   output logic                      o_id_ex_wb,
   output logic                      o_id_ex_mem_read,
   output logic                      o_id_ex_mem_write,
   output logic [CTRL_BUS_SIZE-1:0]  o_id_ex_ctrl,
   output logic                      o_stall,
   output logic [STALL_CNT_SIZE-1:0] o_stall_count
);

   typedef struct packed {
      logic [REG_ADDR_SIZE-1:0] rs;
      logic [REG_ADDR_SIZE-1:0] rt;
      logic [REG_ADDR_SIZE-1:0] rd;
      logic [DATA_BUS_SIZE-1:0] data_a;
      logic [DATA_BUS_SIZE-1:0] data_b;
      logic [DATA_BUS_SIZE-1:0] imm;
      logic                     wb;
      logic                     mem_read;
      logic                     mem_write;
      logic [CTRL_BUS_SIZE-1:0] ctrl;
   } id_ex_t;

   localparam id_ex_t BUBBLE = id_ex_t'(0);
   localparam logic [REG_ADDR_SIZE-1:0]  REG_ZERO = {REG_ADDR_SIZE{1'b0}};
   localparam logic [STALL_CNT_SIZE-1:0] CNT_MAX  = {STALL_CNT_SIZE{1'b1}};
   localparam logic [STALL_CNT_SIZE-1:0] CNT_ONE  = {{(STALL_CNT_SIZE-1){1'b0}}, 1'b1};

   id_ex_t                    stage_r;
   id_ex_t                    stage_d_s;
   id_ex_t                    id_in_s;
   logic [STALL_CNT_SIZE-1:0] cnt_r;
   logic [STALL_CNT_SIZE-1:0] cnt_d_s;
   logic                      rs_match_s;
   logic                      rt_match_s;
   logic                      hazard_s;

   // Hazard detection: the EX load's destination is a source of the ID instruction.
   always_comb begin
      rs_match_s = (stage_r.rt == i_id_rs);
      rt_match_s = i_id_uses_rt & (stage_r.rt == i_id_rt);
      hazard_s   = stage_r.mem_read & stage_r.wb & (stage_r.rt != REG_ZERO)
                 & (rs_match_s | rt_match_s);
      o_stall    = i_enable & hazard_s & ~i_flush;
   end

   // Pack the ID-side inputs into the stage record.
   always_comb begin
      id_in_s           = BUBBLE;
      id_in_s.rs        = i_id_rs;
      id_in_s.rt        = i_id_rt;
      id_in_s.rd        = i_id_rd;
      id_in_s.data_a    = i_id_data_a;
      id_in_s.data_b    = i_id_data_b;
      id_in_s.imm       = i_id_imm;
      id_in_s.wb        = i_id_wb;
      id_in_s.mem_read  = i_id_mem_read;
      id_in_s.mem_write = i_id_mem_write;
      id_in_s.ctrl      = i_id_ctrl;
   end

   // Next-state selection: freeze, then flush, then hazard bubble, then normal load.
   always_comb begin
      stage_d_s = stage_r;
      cnt_d_s   = cnt_r;
      if (!i_enable) begin
         stage_d_s = stage_r;
         cnt_d_s   = cnt_r;
      end else if (i_flush) begin
         stage_d_s = BUBBLE;
         cnt_d_s   = cnt_r;
      end else if (hazard_s) begin
         stage_d_s = BUBBLE;
         if (cnt_r != CNT_MAX) begin
            cnt_d_s = cnt_r + CNT_ONE;
         end else begin
            cnt_d_s = cnt_r;
         end
      end else begin
         stage_d_s = id_in_s;
         cnt_d_s   = cnt_r;
      end
   end

   // Stage and stall-counter registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         stage_r <= BUBBLE;
         cnt_r   <= {STALL_CNT_SIZE{1'b0}};
      end else begin
         stage_r <= stage_d_s;
         cnt_r   <= cnt_d_s;
      end
   end

   assign o_id_ex_rs        = stage_r.rs;
   assign o_id_ex_rt        = stage_r.rt;
   assign o_id_ex_rd        = stage_r.rd;
   assign o_id_ex_data_a    = stage_r.data_a;
   assign o_id_ex_data_b    = stage_r.data_b;
   assign o_id_ex_imm       = stage_r.imm;
   assign o_id_ex_wb        = stage_r.wb;
   assign o_id_ex_mem_read  = stage_r.mem_read;
   assign o_id_ex_mem_write = stage_r.mem_write;
   assign o_id_ex_ctrl      = stage_r.ctrl;
   assign o_stall_count     = cnt_r;

endmodule
